// File: rtl/valve_cmd_sequencer.sv
// Valve command sequencer: buffers host valve commands in a small FIFO and plays
// them out as held static patterns or 3-valve peristaltic pump sequences.
module valve_cmd_sequencer #(
    parameter int unsigned N_VALVES   = 32,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PUMP_BASE  = 20,
    parameter int unsigned PHASE_CYC  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [N_VALVES-1:0] cmd_pattern,
    input  logic [DWELL_W-1:0]  cmd_dwell,
    input  logic                abort,
    output logic [N_VALVES-1:0] valve_o,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PC_W  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int unsigned ENT_W = 1 + N_VALVES + DWELL_W;

    localparam logic [PC_W-1:0]  PC_LAST    = PC_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       LAST_PHASE = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        SET_HOLD,
        PUMP_RUN
    } state_t;

    logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;

    logic                head_op;
    logic [N_VALVES-1:0] head_pat;
    logic [DWELL_W-1:0]  head_dwell;

    state_t              state;
    state_t              state_nxt;
    logic [DWELL_W-1:0]  hold_cnt;
    logic [DWELL_W-1:0]  hold_nxt;
    logic [DWELL_W-1:0]  rep_cnt;
    logic [DWELL_W-1:0]  rep_nxt;
    logic [2:0]          phase;
    logic [2:0]          phase_nxt;
    logic [PC_W-1:0]     phase_cnt;
    logic [PC_W-1:0]     phase_cnt_nxt;
    logic [2:0]          pump_snap;
    logic [2:0]          snap_nxt;
    logic [N_VALVES-1:0] valve_nxt;
    logic [N_VALVES-1:0] valve_restored;

    logic                set_last;
    logic                pump_last;
    logic                cmd_last;

    function automatic logic [2:0] pump_phase_bits(input logic [2:0] ph);
        case (ph)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    // ---------------- command FIFO ----------------
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign cmd_ready  = ~fifo_full & ~abort;
    assign push       = cmd_valid & cmd_ready;

    assign {head_op, head_pat, head_dwell} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_pattern, cmd_dwell};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    assign set_last  = (state == SET_HOLD) && (hold_cnt == '0);
    assign pump_last = (state == PUMP_RUN) && (phase == LAST_PHASE) &&
                       (phase_cnt == PC_LAST) && (rep_cnt == '0);
    assign cmd_last  = set_last | pump_last;

    // Pop on the final cycle of a command too, so queued commands run without a bubble.
    assign pop  = ~abort & ~fifo_empty & ((state == IDLE) | cmd_last);
    assign done = cmd_last & ~abort;
    assign busy = (state != IDLE) | ~fifo_empty;

    always_comb begin
        valve_restored = valve_o;
        valve_restored[PUMP_BASE +: 3] = pump_snap;
    end

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        rep_nxt       = rep_cnt;
        phase_nxt     = phase;
        phase_cnt_nxt = phase_cnt;
        snap_nxt      = pump_snap;
        valve_nxt     = valve_o;

        if (abort) begin
            state_nxt     = IDLE;
            hold_nxt      = '0;
            rep_nxt       = '0;
            phase_nxt     = '0;
            phase_cnt_nxt = '0;
            if (state == PUMP_RUN) begin
                valve_nxt = valve_restored;
            end
        end else begin
            case (state)
                SET_HOLD: begin
                    if (set_last) begin
                        state_nxt = IDLE;
                    end else begin
                        hold_nxt = hold_cnt - DWELL_W'(1);
                    end
                end
                PUMP_RUN: begin
                    if (pump_last) begin
                        state_nxt = IDLE;
                        valve_nxt = valve_restored;
                    end else if (phase_cnt == PC_LAST) begin
                        phase_cnt_nxt = '0;
                        if (phase == LAST_PHASE) begin
                            phase_nxt = '0;
                            rep_nxt   = rep_cnt - DWELL_W'(1);
                        end else begin
                            phase_nxt = phase + 3'd1;
                        end
                        valve_nxt[PUMP_BASE +: 3] = pump_phase_bits(phase_nxt);
                    end else begin
                        phase_cnt_nxt = phase_cnt + PC_W'(1);
                    end
                end
                default: ;
            endcase

            // valve_nxt already carries restored pump bits when a pump just finished.
            if (pop) begin
                phase_nxt     = '0;
                phase_cnt_nxt = '0;
                if (!head_op) begin
                    state_nxt = SET_HOLD;
                    valve_nxt = head_pat;
                    hold_nxt  = (head_dwell == '0) ? '0 : head_dwell - DWELL_W'(1);
                end else if (head_dwell == '0) begin
                    state_nxt = SET_HOLD;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = PUMP_RUN;
                    snap_nxt  = valve_nxt[PUMP_BASE +: 3];
                    valve_nxt[PUMP_BASE +: 3] = pump_phase_bits(3'd0);
                    rep_nxt   = head_dwell - DWELL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            phase     <= '0;
            phase_cnt <= '0;
            pump_snap <= '0;
            valve_o   <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            rep_cnt   <= rep_nxt;
            phase     <= phase_nxt;
            phase_cnt <= phase_cnt_nxt;
            pump_snap <= snap_nxt;
            valve_o   <= valve_nxt;
        end
    end

endmodule

// File: tb/tb_valve_cmd_sequencer.sv
// Bench for valve_cmd_sequencer: directed scenarios plus randomized traffic, checked
// against a cycle-stepped queue/elapsed-time model of the command rules.
module tb_valve_cmd_sequencer;

    localparam int unsigned NV    = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned PB    = 20;
    localparam int unsigned PC    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [NV-1:0] cmd_pattern = '0;
    logic [DW-1:0] cmd_dwell = '0;
    logic          abort = 1'b0;
    logic [NV-1:0] valve_o;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NV-1:0] last_p = '0;

    valve_cmd_sequencer #(
        .N_VALVES  (NV),
        .DWELL_W   (DW),
        .FIFO_DEPTH(DEPTH),
        .PUMP_BASE (PB),
        .PHASE_CYC (PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_pattern(cmd_pattern),
        .cmd_dwell  (cmd_dwell),
        .abort      (abort),
        .valve_o    (valve_o),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic          op;
        logic [NV-1:0] pat;
        int unsigned   dw;
    } cmd_t;

    cmd_t          mq[$];
    bit            m_active = 1'b0;
    bit            m_pump   = 1'b0;
    int unsigned   m_el     = 0;
    int unsigned   m_tot    = 0;
    logic [2:0]    m_snap   = '0;
    logic [NV-1:0] m_valve  = '0;

    function automatic logic [2:0] pump_bits(input int unsigned e);
        int unsigned ph;
        ph = (e / PC) % 6;
        case (ph)
            0:       return 3'b100;
            1:       return 3'b110;
            2:       return 3'b010;
            3:       return 3'b011;
            4:       return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [NV+2:0] exp_vec();
        logic d;
        logic b;
        logic r;
        d = m_active && (m_el == m_tot - 1) && !abort;
        b = m_active || (mq.size() != 0);
        r = (mq.size() < DEPTH) && !abort;
        return {m_valve, d, b, r};
    endfunction

    always @(posedge clk) begin : model_step
        cmd_t c;
        bit   rdy;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_valve  = '0;
        end else if (abort) begin
            if (m_active && m_pump) m_valve[PB +: 3] = m_snap;
            mq.delete();
            m_active = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (m_active) begin
                if (m_el == m_tot - 1) begin
                    if (m_pump) m_valve[PB +: 3] = m_snap;
                    m_active = 1'b0;
                end else begin
                    m_el++;
                    if (m_pump) m_valve[PB +: 3] = pump_bits(m_el);
                end
            end
            if (!m_active && mq.size() > 0) begin
                c = mq.pop_front();
                m_active = 1'b1;
                m_el     = 0;
                m_pump   = 1'b0;
                if (!c.op) begin
                    m_valve = c.pat;
                    m_tot   = (c.dw == 0) ? 1 : c.dw;
                end else if (c.dw == 0) begin
                    m_tot = 1;
                end else begin
                    m_pump = 1'b1;
                    m_snap = m_valve[PB +: 3];
                    m_valve[PB +: 3] = pump_bits(0);
                    m_tot = 6 * PC * c.dw;
                end
            end
            if (cmd_valid && rdy) begin
                c.op  = cmd_op;
                c.pat = cmd_pattern;
                c.dw  = cmd_dwell;
                mq.push_back(c);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic op, input logic [NV-1:0] pat,
                         input logic [DW-1:0] dw, input logic ab, input logic r);
        @(negedge clk);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_pattern = pat;
        cmd_dwell   = dw;
        abort       = ab;
        rst         = r;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        n_tests++;
        if ({valve_o, done, busy, cmd_ready} !== {{NV{1'b0}}, 3'b001}) begin
            n_fail++;
            $display("FAIL reset: got valve=%h done=%b busy=%b ready=%b, want 0/0/0/1",
                     valve_o, done, busy, cmd_ready);
        end
    endtask

    task automatic test_single_set();
        for (int i = 0; i <= 6; i++) begin
            if (i == 0) drive(1'b1, 1'b0, NV'(32'hFF), DW'(3), 1'b0, 1'b0);
            else        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_set model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            if (i >= 2 && i <= 4) begin
                n_tests++;
                if (valve_o !== NV'(32'hFF)) begin
                    n_fail++;
                    $display("FAIL single_set valve cyc=%0d got %h want ff", i, valve_o);
                end
            end
            if (i == 4 || i == 5) begin
                n_tests++;
                if ({done, busy} !== ((i == 4) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL single_set done/busy cyc=%0d got %b%b", i, done, busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NV-1:0] pats [5];
        int unsigned   dws  [5];
        int            n_done;
        bit            accepted;
        bit            idle;
        dws = '{12, 1, 0, 2, 5};
        for (int k = 0; k < 5; k++) pats[k] = NV'($urandom);
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, pats[k], DW'(dws[k]), 1'b0, 1'b0);
            if (done === 1'b1) n_done++;
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back model push=%0d got %h want %h", k,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
        end
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            drive(1'b1, 1'b0, NV'(32'hA5A5_0F0F), DW'(2), 1'b0, 1'b0);
            if (done === 1'b1) n_done++;
            if (i == 0) begin
                n_tests++;
                if (cmd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL back_to_back full_stall got ready=%b want 0", cmd_ready);
                end
            end
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back model stall=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            accepted = exp_vec()[0];
        end
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            if (done === 1'b1) n_done++;
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back model drain=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            idle = !m_active && (mq.size() == 0);
        end
        n_tests++;
        if (!accepted || !idle || n_done != 6) begin
            n_fail++;
            $display("FAIL back_to_back done_count got %0d want 6 (accepted=%0b idle=%0b)",
                     n_done, accepted, idle);
        end
    endtask

    task automatic test_pump();
        logic [2:0] seq [6];
        int         o;
        seq = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        for (int i = 0; i <= 53; i++) begin
            if (i == 0)      drive(1'b1, 1'b0, '0, DW'(1), 1'b0, 1'b0);
            else if (i == 1) drive(1'b1, 1'b1, NV'($urandom), DW'(2), 1'b0, 1'b0);
            else             drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL pump model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            o = i - 3;
            if (o >= 0 && o < 48) begin
                n_tests++;
                if (valve_o !== (NV'(seq[(o / PC) % 6]) << PB)) begin
                    n_fail++;
                    $display("FAIL pump phase off=%0d got %h want bits %b", o, valve_o,
                             seq[(o / PC) % 6]);
                end
            end
            if (o == 47 || o == 48) begin
                n_tests++;
                if ({done, valve_o} !== {(o == 47), ((o == 47) ? (NV'(3'b101) << PB) : NV'(0))}) begin
                    n_fail++;
                    $display("FAIL pump end off=%0d got done=%b valve=%h", o, done, valve_o);
                end
            end
        end
    endtask

    task automatic test_pump_abort();
        int n_done;
        n_done = 0;
        for (int i = 0; i <= 20; i++) begin
            if (i == 0)       drive(1'b1, 1'b0, NV'(32'h0070_0000), DW'(1), 1'b0, 1'b0);
            else if (i == 1)  drive(1'b1, 1'b1, '0, DW'(1), 1'b0, 1'b0);
            else if (i == 16) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
            else              drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            if (i >= 3 && done === 1'b1) n_done++;
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL pump_abort model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            if (i == 16) begin
                n_tests++;
                if (valve_o[PB +: 3] !== 3'b011) begin
                    n_fail++;
                    $display("FAIL pump_abort phase3 got %b want 011", valve_o[PB +: 3]);
                end
            end
            if (i == 17) begin
                n_tests++;
                if ({valve_o, busy} !== {NV'(32'h0070_0000), 1'b0}) begin
                    n_fail++;
                    $display("FAIL pump_abort restore got valve=%h busy=%b want 00700000/0",
                             valve_o, busy);
                end
            end
        end
        n_tests++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL pump_abort done_count got %0d want 0", n_done);
        end
    endtask

    task automatic test_abort_full();
        last_p = NV'($urandom) | NV'(1);
        for (int i = 0; i <= 8; i++) begin
            if (i == 0)     drive(1'b1, 1'b0, last_p, DW'(20), 1'b0, 1'b0);
            else if (i < 5) drive(1'b1, 1'b0, NV'($urandom), DW'(1), 1'b0, 1'b0);
            else if (i == 5) drive(1'b1, 1'b0, NV'($urandom), DW'(1), 1'b1, 1'b0);
            else            drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort_full model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            if (i == 5) begin
                n_tests++;
                if (cmd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_full ready got %b want 0", cmd_ready);
                end
            end
            if (i == 6) begin
                n_tests++;
                if ({valve_o, busy} !== {last_p, 1'b0}) begin
                    n_fail++;
                    $display("FAIL abort_full flush got valve=%h busy=%b want %h/0",
                             valve_o, busy, last_p);
                end
            end
        end
    endtask

    task automatic test_pump_zero();
        for (int i = 0; i <= 5; i++) begin
            if (i == 0)      drive(1'b1, 1'b1, NV'($urandom), DW'(0), 1'b0, 1'b0);
            else if (i == 1) drive(1'b1, 1'b0, NV'(1), DW'(1), 1'b0, 1'b0);
            else             drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL pump_zero model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
            if (i == 2 || i == 3) begin
                n_tests++;
                if ({valve_o, done} !== {((i == 2) ? last_p : NV'(1)), 1'b1}) begin
                    n_fail++;
                    $display("FAIL pump_zero cyc=%0d got valve=%h done=%b", i, valve_o, done);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pump_zero idle got busy=%b want 0", busy);
                end
            end
        end
    endtask

    task automatic test_random();
        logic          v;
        logic          op;
        logic          ab;
        logic          r;
        logic [DW-1:0] dw;
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 3) == 0);
            dw = op ? DW'($urandom_range(0, 2)) : DW'($urandom_range(0, 4));
            ab = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 199) == 0);
            drive(v, op, NV'($urandom), dw, ab, r);
            n_tests++;
            if ({valve_o, done, busy, cmd_ready} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random model cyc=%0d got %h want %h", i,
                         {valve_o, done, busy, cmd_ready}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_back_to_back();
        test_pump();
        test_pump_abort();
        test_abort_full();
        test_pump_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
